// File: rtl/two_level_bp_pkg.sv
// Shared types, default sizes and the saturating-counter helper for the
// two-level branch predictor.
package two_level_bp_pkg;

  typedef enum logic {
    BP_LOCAL  = 1'b0,
    BP_GSHARE = 1'b1
  } bp_mode_t;

  localparam int BP_BHT_IDX_BITS = 5;
  localparam int BP_HIST_LEN     = 6;
  localparam int BP_CTR_BITS     = 2;

  // Metadata carried down the pipeline with each branch, at the default sizes.
  typedef struct packed {
    logic [BP_HIST_LEN-1:0]     pht_idx;
    logic [BP_HIST_LEN-1:0]     hist;
    logic [BP_BHT_IDX_BITS-1:0] bht_idx;
    logic [BP_CTR_BITS-1:0]     ctr;
  } bp_meta_t;

  // Counters are at most 4 bits wide; narrower counters ride in the low bits.
  function automatic logic [3:0] bp_sat_update(input logic [3:0] ctr,
                                               input logic       taken,
                                               input int         width);
    logic [3:0] max_val;
    max_val = 4'((1 << width) - 1);
    if (taken) begin
      return (ctr == max_val) ? ctr : ctr + 4'd1;
    end
    return (ctr == 4'd0) ? ctr : ctr - 4'd1;
  endfunction

endpackage

// File: rtl/bp_sat_ctr_table.sv
// Table of 2^IDX_BITS saturating counters: one combinational read port and one
// read-modify-write port. Reset loads every entry with "weakly not-taken".
module bp_sat_ctr_table
  import two_level_bp_pkg::*;
#(
  parameter int IDX_BITS = BP_HIST_LEN,
  parameter int CTR_BITS = BP_CTR_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [CTR_BITS-1:0] rd_ctr,
  input  logic                upd_en,
  input  logic [IDX_BITS-1:0] upd_idx,
  input  logic                upd_taken
);

  localparam int                DEPTH     = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic [CTR_BITS-1:0] mem_reg [DEPTH];
  logic [CTR_BITS-1:0] upd_next;

  // The increment/decrement starts from the live entry, not the fetch-time copy.
  assign upd_next = CTR_BITS'(bp_sat_update(4'(mem_reg[upd_idx]), upd_taken, CTR_BITS));
  assign rd_ctr   = mem_reg[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= CTR_INIT;
      end
    end else if (upd_en) begin
      mem_reg[upd_idx] <= upd_next;
    end
  end

endmodule

// File: rtl/two_level_bp.sv
// Two-level conditional-branch predictor with local-history or gshare indexing,
// speculative global history with mispredict repair, and perf counters.
module two_level_bp
  import two_level_bp_pkg::*;
#(
  parameter int       BHT_IDX_BITS = BP_BHT_IDX_BITS,
  parameter int       HIST_LEN     = BP_HIST_LEN,
  parameter int       CTR_BITS     = BP_CTR_BITS,
  parameter bp_mode_t MODE         = BP_LOCAL,
  localparam int      META_W       = 2*HIST_LEN + BHT_IDX_BITS + CTR_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_valid,
  input  logic [31:0]       pred_pc,
  output logic              pred_taken,
  output logic [META_W-1:0] pred_meta,
  input  logic              upd_valid,
  input  logic [META_W-1:0] upd_meta,
  input  logic              upd_taken,
  output logic              upd_mispredict,
  output logic [31:0]       cnt_branches,
  output logic [31:0]       cnt_mispred
);

  logic [BHT_IDX_BITS-1:0] lk_bht_idx;
  logic [HIST_LEN-1:0]     lk_hist;
  logic [HIST_LEN-1:0]     lk_pht_idx;
  logic [CTR_BITS-1:0]     lk_ctr;

  logic [CTR_BITS-1:0]     u_ctr;
  logic [BHT_IDX_BITS-1:0] u_bht_idx;
  logic [HIST_LEN-1:0]     u_hist;
  logic [HIST_LEN-1:0]     u_pht_idx;

  logic [31:0] cnt_branches_reg;
  logic [31:0] cnt_mispred_reg;

  // Which inputs matter depends on MODE; fold them all here to keep lint quiet.
  logic unused_inputs;
  assign unused_inputs = ^{pred_valid, pred_pc, upd_meta};

  assign lk_bht_idx = pred_pc[BHT_IDX_BITS+1:2];

  assign u_ctr     = upd_meta[CTR_BITS-1:0];
  assign u_bht_idx = upd_meta[CTR_BITS +: BHT_IDX_BITS];
  assign u_hist    = upd_meta[CTR_BITS+BHT_IDX_BITS +: HIST_LEN];
  assign u_pht_idx = upd_meta[META_W-1 -: HIST_LEN];

  assign pred_taken     = lk_ctr[CTR_BITS-1];
  assign pred_meta      = {lk_pht_idx, lk_hist, lk_bht_idx, lk_ctr};
  assign upd_mispredict = upd_valid & (u_ctr[CTR_BITS-1] != upd_taken);

  bp_sat_ctr_table #(
    .IDX_BITS (HIST_LEN),
    .CTR_BITS (CTR_BITS)
  ) u_pht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (lk_pht_idx),
    .rd_ctr    (lk_ctr),
    .upd_en    (upd_valid),
    .upd_idx   (u_pht_idx),
    .upd_taken (upd_taken)
  );

  generate
    if (MODE == BP_LOCAL) begin : g_local
      logic [HIST_LEN-1:0] bht_reg [1 << BHT_IDX_BITS];

      // Local history is only ever written with resolved outcomes.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < (1 << BHT_IDX_BITS); i++) begin
            bht_reg[i] <= '0;
          end
        end else if (upd_valid) begin
          bht_reg[u_bht_idx] <= {bht_reg[u_bht_idx][HIST_LEN-2:0], upd_taken};
        end
      end

      assign lk_hist    = bht_reg[lk_bht_idx];
      assign lk_pht_idx = lk_hist;
    end else begin : g_gshare
      logic [HIST_LEN-1:0] ghr_reg;
      logic [HIST_LEN-1:0] ghr_next;

      // A mispredict rebuilds history from the branch's own snapshot, which
      // overrides any speculative shift from a fetch in the same cycle.
      always_comb begin
        ghr_next = ghr_reg;
        if (upd_mispredict) begin
          ghr_next = {u_hist[HIST_LEN-2:0], upd_taken};
        end else if (pred_valid) begin
          ghr_next = {ghr_reg[HIST_LEN-2:0], pred_taken};
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          ghr_reg <= '0;
        end else begin
          ghr_reg <= ghr_next;
        end
      end

      assign lk_hist    = ghr_reg;
      assign lk_pht_idx = ghr_reg ^ pred_pc[HIST_LEN+1:2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_branches_reg <= '0;
      cnt_mispred_reg  <= '0;
    end else begin
      if (upd_valid && (cnt_branches_reg != 32'hFFFF_FFFF)) begin
        cnt_branches_reg <= cnt_branches_reg + 32'd1;
      end
      if (upd_mispredict && (cnt_mispred_reg != 32'hFFFF_FFFF)) begin
        cnt_mispred_reg <= cnt_mispred_reg + 32'd1;
      end
    end
  end

  assign cnt_branches = cnt_branches_reg;
  assign cnt_mispred  = cnt_mispred_reg;

endmodule

// File: tb/tb_two_level_bp.sv
// Directed bench: a default local-history predictor and a 3-bit-counter gshare
// predictor, each driven with hand-computed vectors.
module tb_two_level_bp;
  import two_level_bp_pkg::*;

  localparam int LW = 19;  // 2*6 + 5 + 2
  localparam int GW = 20;  // 2*6 + 5 + 3

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          l_rst, l_pv, l_pt, l_uv, l_ut, l_mis;
  logic [31:0]   l_pc, l_cb, l_cm;
  logic [LW-1:0] l_pm, l_um;

  logic          g_rst, g_pv, g_pt, g_uv, g_ut, g_mis;
  logic [31:0]   g_pc, g_cb, g_cm;
  logic [GW-1:0] g_pm, g_um;

  int errors = 0;
  int checks = 0;

  two_level_bp u_loc (
    .clk(clk), .rst(l_rst), .pred_valid(l_pv), .pred_pc(l_pc), .pred_taken(l_pt),
    .pred_meta(l_pm), .upd_valid(l_uv), .upd_meta(l_um), .upd_taken(l_ut),
    .upd_mispredict(l_mis), .cnt_branches(l_cb), .cnt_mispred(l_cm)
  );

  two_level_bp #(.CTR_BITS(3), .MODE(BP_GSHARE)) u_gs (
    .clk(clk), .rst(g_rst), .pred_valid(g_pv), .pred_pc(g_pc), .pred_taken(g_pt),
    .pred_meta(g_pm), .upd_valid(g_uv), .upd_meta(g_um), .upd_taken(g_ut),
    .upd_mispredict(g_mis), .cnt_branches(g_cb), .cnt_mispred(g_cm)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    l_rst = 1; l_pv = 0; l_pc = 0; l_uv = 0; l_um = '0; l_ut = 0;
    g_rst = 1; g_pv = 0; g_pc = 0; g_uv = 0; g_um = '0; g_ut = 0;
    tick; tick;
    l_rst = 0; g_rst = 0;

    // ---------------- LOCAL, 2-bit ----------------
    l_pc = 32'h100; l_pv = 1; #1;
    check("loc_rst_taken", l_pt, 0);
    check("loc_rst_meta", l_pm, 19'd1);
    check("loc_rst_cnt", {l_cb, l_cm}, 64'd0);

    l_pc = 32'h104; #1;
    check("loc_0x104_meta", l_pm, 19'd5);
    l_uv = 1; l_um = 19'd5; l_ut = 1; #1;
    check("loc_upd1_mis", l_mis, 1);
    tick;
    l_uv = 0; l_pc = 32'h100; #1;
    check("loc_pht0_10", l_pm, 19'd2);
    check("loc_pht0_taken", l_pt, 1);
    l_pc = 32'h104; #1;
    check("loc_bht1_000001", l_pm, 19'd8325);
    check("loc_cnt_mis1", l_cm, 32'd1);

    // Stale metadata: counter increments from the live 10, not from meta's 01.
    l_uv = 1; l_um = 19'd5; l_ut = 1; #1;
    check("loc_upd2_mis", l_mis, 1);
    tick;
    l_uv = 0; l_pc = 32'h100; #1;
    check("loc_pht0_11", l_pm, 19'd3);
    l_pc = 32'h104; #1;
    check("loc_bht1_000011", l_pm, 19'd24965);
    check("loc_cnt_br2", l_cb, 32'd2);

    // Same-cycle hazard on pht_idx 3 (bht_idx 31 is otherwise unused).
    l_uv = 1; l_um = 19'd24701; l_ut = 1; #1;
    check("loc_haz_old", l_pm, 19'd24965);
    check("loc_haz_old_taken", l_pt, 0);
    tick;
    l_uv = 0; #1;
    check("loc_haz_new", l_pm, 19'd24966);
    check("loc_haz_new_taken", l_pt, 1);
    check("loc_cnt_br3", l_cb, 32'd3);
    check("loc_cnt_mis3", l_cm, 32'd3);

    // Perf counters from a clean reset: 10 updates, the first 3 mispredict.
    l_rst = 1; tick; l_rst = 0;
    for (int i = 0; i < 10; i++) begin
      l_uv = 1; l_um = {6'd10, 6'd0, 5'd20, 2'b00}; l_ut = (i < 3); #1;
      check($sformatf("loc_perf_mis%0d", i), l_mis, (i < 3));
      tick;
    end
    l_uv = 0; #1;
    check("loc_perf_br", l_cb, 32'd10);
    check("loc_perf_mis", l_cm, 32'd3);

    // Reset together with an update: the update is dropped.
    l_uv = 1; l_um = {6'd0, 6'd0, 5'd1, 2'b00}; l_ut = 1; l_rst = 1;
    tick;
    l_rst = 0; l_uv = 0; l_pc = 32'h100; #1;
    check("loc_rst2_cnt", {l_cb, l_cm}, 64'd0);
    check("loc_rst2_pht0", l_pm, 19'd1);
    l_pc = 32'h104; #1;
    check("loc_rst2_bht1", l_pm, 19'd5);

    // ---------------- GSHARE, 3-bit ----------------
    g_pc = 32'h14; #1;
    check("gs_rst_meta", g_pm, 20'd81963);
    check("gs_rst_taken", g_pt, 0);
    for (int k = 1; k <= 9; k++) begin
      g_uv = 1; g_um = 20'd81924; g_ut = 1;
      tick;
      g_uv = 0; #1;
      check($sformatf("gs_sat_k%0d", k), g_pm[2:0], (3 + k > 7) ? 7 : 3 + k);
    end
    g_uv = 1; g_ut = 0; #1;
    check("gs_dec_mis", g_mis, 1);
    tick;
    g_uv = 0; #1;
    check("gs_dec_ctr", g_pm[2:0], 3'd6);
    check("gs_dec_taken", g_pt, 1);

    // GHR speculation and repair.
    g_rst = 1; tick; g_rst = 0;
    g_pc = 32'h0; g_pv = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("gs_spec_nt%0d", c), g_pt, 0);
      tick;
    end
    g_pv = 0; #1;
    check("gs_ghr_zero", g_pm, 20'd3);
    g_pv = 1; g_uv = 1; g_um = 20'd1033472; g_ut = 1; #1;
    check("gs_repair_mis", g_mis, 1);
    tick;
    g_pv = 0; g_uv = 0; #1;
    check("gs_ghr_001011", g_pm, 20'd183043);
    g_pc = 32'h2C; #1;
    check("gs_xor_wrap", g_pm, 20'd2907);
    g_pc = 32'hD0; #1;
    check("gs_pht63_taken", g_pt, 1);
    g_pv = 1;
    tick;
    g_pv = 0; g_pc = 32'h0; #1;
    check("gs_ghr_shift_t", g_pm, 20'd382723);
    check("gs_cnt", {g_cb, g_cm}, {32'd1, 32'd1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
